// File: rtl/prio_encoder_stream.sv
// Registered streaming priority encoder with valid/ready on both sides; DRAIN=1 emits one beat per set bit.
// Optional ENCODER_ERR_CNT_EN macro builds a saturating counter of multi-bit vectors on err_count.
module prio_encoder_stream #(
  parameter int IN_WIDTH  = 16,
  parameter int MSB_FIRST = 0,
  parameter int DRAIN     = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_WIDTH-1:0]         encoder_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(IN_WIDTH)-1:0] binary_out,
  output logic                        out_hit,
  output logic                        out_last,
  output logic                        out_multi,
  output logic [7:0]                  err_count
);
  localparam int OUT_W = $clog2(IN_WIDTH);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] resid_q, resid_d;
  logic [OUT_W-1:0]    bin_q, bin_d;
  logic                hit_q, hit_d, last_q, last_d, multi_q, multi_d;
  logic [IN_WIDTH-1:0] eff, src, rem;
  logic [OUT_W-1:0]    sel;
  logic                accept, beat_done;

  // Later loop iterations overwrite earlier ones, so the last set bit visited wins.
  function automatic logic [OUT_W-1:0] pick(input logic [IN_WIDTH-1:0] v);
    pick = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (MSB_FIRST != 0) begin
        if (v[i]) pick = OUT_W'(i);
      end else begin
        if (v[IN_WIDTH-1-i]) pick = OUT_W'(IN_WIDTH-1-i);
      end
    end
  endfunction

  assign out_valid  = (state_q == HOLD);
  assign in_ready   = (state_q == IDLE) || (out_valid && out_ready && last_q);
  assign accept     = in_valid && in_ready;
  assign beat_done  = out_valid && out_ready;
  assign binary_out = bin_q;
  assign out_hit    = hit_q;
  assign out_last   = last_q;
  assign out_multi  = multi_q;

  always_comb begin
    eff     = enable ? encoder_in : '0;
    src     = accept ? eff : resid_q;
    sel     = pick(src);
    rem     = src & ~(IN_WIDTH'(1) << sel);
    state_d = state_q;
    resid_d = resid_q;
    bin_d   = bin_q;
    hit_d   = hit_q;
    last_d  = last_q;
    multi_d = multi_q;
    if (accept) begin
      state_d = HOLD;
      bin_d   = sel;
      hit_d   = |eff;
      last_d  = (DRAIN == 0) || (rem == '0);
      multi_d = |(eff & (eff - IN_WIDTH'(1)));
      resid_d = (DRAIN != 0) ? rem : '0;
    end else if (beat_done) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        // Residual is non-zero here, so the next pick is always a real bit.
        bin_d   = sel;
        hit_d   = 1'b1;
        last_d  = (rem == '0);
        resid_d = rem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      resid_q <= '0;
      bin_q   <= '0;
      hit_q   <= 1'b0;
      last_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      resid_q <= resid_d;
      bin_q   <= bin_d;
      hit_q   <= hit_d;
      last_q  <= last_d;
      multi_q <= multi_d;
    end
  end

`ifdef ENCODER_ERR_CNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   err_q <= 8'd0;
    else if (accept && multi_d && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Three encoder builds (DRAIN=0; DRAIN=1 LSB-first; DRAIN=1 MSB-first) checked by directed steps
// plus a per-build scoreboard of expected beats.
module tb_prio_encoder_stream;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [2:0]      in_valid = '0;
  logic [15:0]     encoder_in = '0;
  logic            out_ready = 1'b0;
  logic [2:0]      ir, ov, hit, lst, mul;
  logic [2:0][3:0] bo;
  logic [2:0][7:0] ec;

  int nerr = 0;
  int nchk = 0;

`ifdef ENCODER_ERR_CNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  typedef struct {
    logic [3:0] idx;
    logic       hit;
    logic       last;
    logic       multi;
  } beat_t;

  beat_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    prio_encoder_stream #(
      .IN_WIDTH (16),
      .MSB_FIRST((g == 2) ? 1 : 0),
      .DRAIN    ((g == 0) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .in_valid(in_valid[g]), .in_ready(ir[g]), .encoder_in(encoder_in),
      .out_valid(ov[g]), .out_ready(out_ready), .binary_out(bo[g]),
      .out_hit(hit[g]), .out_last(lst[g]), .out_multi(mul[g]), .err_count(ec[g])
    );
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
    nchk++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp_v);
    end
  endtask

  function automatic void push(input int k, input beat_t b);
    case (k)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic beat_t pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Expected beat list: build 0 keeps only the first pick, build 2 walks bits from the top.
  function automatic void model(input int k, input logic [15:0] v, input logic en);
    logic [15:0] e;
    int          n;
    int          cnt;
    beat_t       b;
    e   = en ? v : 16'h0;
    n   = $countones(e);
    cnt = 0;
    if (e == 16'h0) begin
      b = '{idx: 4'd0, hit: 1'b0, last: 1'b1, multi: 1'b0};
      push(k, b);
      return;
    end
    for (int j = 0; j < 16; j++) begin
      int i;
      i = (k == 2) ? 15 - j : j;
      if (e[i]) begin
        cnt++;
        b = '{idx: 4'(i), hit: 1'b1, last: (k == 0) || (cnt == n), multi: n > 1};
        push(k, b);
        if (k == 0) break;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && out_ready) begin
          if (qsize(k) == 0) begin
            chk("unexpected_beat", k, 32'd1, 32'd0);
          end else begin
            beat_t e;
            e = pop(k);
            chk("beat", k, {bo[k], hit[k], lst[k], mul[k]}, {e.idx, e.hit, e.last, e.multi});
          end
        end
        if (in_valid[k] && ir[k]) model(k, encoder_in, enable);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a vector to the masked builds and drop each one's valid once it has been taken.
  task automatic send(input logic [2:0] m, input logic [15:0] v, input logic en);
    logic [2:0] acc;
    encoder_in = v;
    enable     = en;
    in_valid   = m;
    for (int c = 0; c < 50 && in_valid != 3'b000; c++) begin
      @(negedge clk);
      acc = in_valid & ir;
      @(posedge clk);
      #1;
      in_valid = in_valid & ~acc;
    end
    chk("accept_timeout", 0, 32'(in_valid), 32'd0);
    in_valid = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out", k, {ov[k], bo[k], hit[k], lst[k], mul[k]}, 32'd0);
      chk("rst_err", k, 32'(ec[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 0, 32'(ir), 32'b111);

    // Single one-hot vector, one cycle latency, back to idle after the beat.
    out_ready = 1'b1;
    send(3'b001, 16'h0010, 1'b1);
    chk("t1_out", 0, {ov[0], bo[0], hit[0], lst[0], mul[0]}, {1'b1, 4'd4, 1'b1, 1'b1, 1'b0});
    step();
    chk("t1_idle", 0, {ov[0], ir[0]}, 2'b01);

    // Drain in both priority orders.
    send(3'b110, 16'h8101, 1'b1);
    chk("t2_b0_lsb", 1, {bo[1], lst[1], mul[1], ir[1]}, {4'd0, 1'b0, 1'b1, 1'b0});
    chk("t2_b0_msb", 2, {bo[2], lst[2], mul[2], ir[2]}, {4'd15, 1'b0, 1'b1, 1'b0});
    step();
    chk("t2_b1_lsb", 1, {bo[1], lst[1], mul[1], ir[1]}, {4'd8, 1'b0, 1'b1, 1'b0});
    chk("t2_b1_msb", 2, {bo[2], lst[2], mul[2], ir[2]}, {4'd8, 1'b0, 1'b1, 1'b0});
    step();
    chk("t2_b2_lsb", 1, {bo[1], lst[1], mul[1], ir[1]}, {4'd15, 1'b1, 1'b1, 1'b1});
    chk("t2_b2_msb", 2, {bo[2], lst[2], mul[2], ir[2]}, {4'd0, 1'b1, 1'b1, 1'b1});
    step();
    chk("t2_idle", 0, 32'(ov), 32'd0);

    // Back-pressure, then a back-to-back accept with no bubble.
    out_ready = 1'b0;
    send(3'b001, 16'h0005, 1'b1);
    in_valid   = 3'b001;
    encoder_in = 16'h0100;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_hold", 0, {ov[0], bo[0], hit[0], lst[0], mul[0], ir[0]},
          {1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    step();
    in_valid = '0;
    chk("t3_b2b", 0, {ov[0], bo[0], mul[0]}, {1'b1, 4'd8, 1'b0});
    step();
    chk("t3_idle", 0, 32'(ov[0]), 32'd0);

    // Disabled and empty vectors.
    send(3'b111, 16'hFFFF, 1'b0);
    for (int k = 0; k < 3; k++)
      chk("t4_dis", k, {ov[k], bo[k], hit[k], lst[k], mul[k]}, {1'b1, 4'd0, 1'b0, 1'b1, 1'b0});
    step();
    send(3'b111, 16'h0000, 1'b1);
    for (int k = 0; k < 3; k++)
      chk("t4_zero", k, {ov[k], bo[k], hit[k], lst[k], mul[k]}, {1'b1, 4'd0, 1'b0, 1'b1, 1'b0});
    step();

    // Reset in the middle of a drain.
    send(3'b010, 16'h00F0, 1'b1);
    chk("t5_b0", 1, 32'(bo[1]), 32'd4);
    step();
    chk("t5_b1", 1, 32'(bo[1]), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("t5_async", 1, 32'(ov[1]), 32'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_ready", 0, 32'(ir), 32'b111);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_quiet", 0, 32'(ov), 32'd0);
    end

    // Error counter saturation on multi-bit vectors.
    chk("t6_start", 0, 32'(ec[0]), 32'd0);
    for (int i = 0; i < 300; i++) begin
      send(3'b001, 16'h0003, 1'b1);
      if (i == 99) chk("t6_100", 0, 32'(ec[0]), (ERR_EN != 0) ? 32'd100 : 32'd0);
    end
    chk("t6_sat", 0, 32'(ec[0]), (ERR_EN != 0) ? 32'd255 : 32'd0);
    send(3'b001, 16'h0040, 1'b1);
    step();
    chk("t6_onehot", 0, 32'(ec[0]), (ERR_EN != 0) ? 32'd255 : 32'd0);
    chk("t6_other", 1, 32'(ec[1]), 32'd0);
    step();

    for (int k = 0; k < 3; k++) chk("sb_empty", k, 32'(qsize(k)), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
